// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; flush wins over a same-cycle push so nothing survives it.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: credit-limited imem issue, in-order response capture, redirect flush.
// Define FETCH_PERF_CNT_EN to build the decode-starvation counter on perf_stall_cnt.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     perf_stall_cnt
);

  localparam int QCW = $clog2(DEPTH + 1);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            req_fire, rsp_accept, rsp_keep, rsp_drop, q_pop;
  fetch_entry_t    q_push_data, q_head;
  logic [QCW-1:0]  q_count;
  logic            q_full, q_empty;
  logic [XLEN-1:0] inflight_pc;
  logic [OW-1:0]   if_count;
  logic            if_full, if_empty;
  logic            fifo_status_unused;

  assign fifo_status_unused = ^{q_full, if_count, if_full, if_empty};

  // Every issued request already owns a queue slot, so responses never need backpressure.
  always_comb begin
    imem_req_valid = rst && !redirect_valid
                     && (outstanding_q < OW'(MAX_OUTSTANDING))
                     && ((int'(q_count) + int'(outstanding_q)) < DEPTH);
    req_fire      = imem_req_valid && imem_req_ready;
    rsp_accept    = imem_rsp_valid && (outstanding_q != '0);
    rsp_drop      = rsp_accept && (drop_cnt_q != '0);
    rsp_keep      = rsp_accept && (drop_cnt_q == '0);
    outstanding_d = outstanding_q + OW'(req_fire) - OW'(rsp_accept);
    drop_cnt_d    = redirect_valid ? outstanding_d : drop_cnt_q - OW'(rsp_drop);
    q_push_data.pc    = inflight_pc;
    q_push_data.instr = imem_rsp_data;
    q_pop = !q_empty && id_ready;
    if (!rst)                pc_next = pc;
    else if (redirect_valid) pc_next = redirect_pc;
    else if (req_fire)       pc_next = pc + 32'd4;
    else                     pc_next = pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_inflight (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (pc),
    .pop       (rsp_keep),
    .flush     (redirect_valid),
    .pop_data  (inflight_pc),
    .count     (if_count),
    .full      (if_full),
    .empty     (if_empty)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .pop_data  (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign imem_req_addr = pc;
  assign id_valid      = !q_empty;
  assign id_pc         = q_head.pc;
  assign id_instr      = q_empty ? INSTR_NOP : q_head.instr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (id_ready && !id_valid && (perf_cnt_q != '1)) perf_cnt_d = perf_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_cnt_q <= '0;
    else      perf_cnt_q <= perf_cnt_d;
  end

  assign perf_stall_cnt = perf_cnt_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule
